dmem_write_buffer: RTL and testbench

//  Posted-write buffer downstream of the single-cycle mips core's data port (memwrite/aluout/writedata/readdata).

---
 rtl/dmem_write_buffer_if.sv | 39 +++
 rtl/dmem_write_buffer.sv | 131 +++++++++++++
 tb/tb_dmem_write_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_write_buffer_if.sv
// Core data-port and backing-memory signals of the posted-write buffer.
// WBUF_FLUSH_EN adds the flush request to the bundle.
interface dmem_write_buffer_if #(
    parameter int unsigned AW = 32
);
    logic          memwrite;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   readdata;
    logic          stall;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          empty;
`ifdef WBUF_FLUSH_EN
    logic          flush;

    modport master (
        output memwrite, addr, wdata, mem_rdata, mem_ack, flush,
        input  readdata, stall, mem_raddr, mem_req, mem_addr, mem_wdata, empty
    );
    modport slave (
        input  memwrite, addr, wdata, mem_rdata, mem_ack, flush,
        output readdata, stall, mem_raddr, mem_req, mem_addr, mem_wdata, empty
    );
`else
    modport master (
        output memwrite, addr, wdata, mem_rdata, mem_ack,
        input  readdata, stall, mem_raddr, mem_req, mem_addr, mem_wdata, empty
    );
    modport slave (
        input  memwrite, addr, wdata, mem_rdata, mem_ack,
        output readdata, stall, mem_raddr, mem_req, mem_addr, mem_wdata, empty
    );
`endif
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-write FIFO between the core data port and a slower data memory, with load forwarding.
// Optional WBUF_FLUSH_EN: flush input rejects every store until the buffer drains.
module dmem_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    dmem_write_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic             full, flush_on, push, pop;
    logic             req_q, req_d;
    logic [AW-1:0]    maddr_q, maddr_d;
    logic [31:0]      mwdata_q, mwdata_d;
    logic [31:0]      rdata;
    logic [PW-1:0]    idx;

`ifdef WBUF_FLUSH_EN
    assign flush_on = bus.flush;
`else
    assign flush_on = 1'b0;
`endif

    // A pop in the same cycle does not relieve a full-buffer stall.
    assign full       = (count_q == CW'(DEPTH));
    assign bus.stall  = bus.memwrite & (full | flush_on);
    assign push       = bus.memwrite & ~bus.stall;
    assign bus.empty  = (count_q == '0);

    assign bus.mem_raddr = bus.addr;
    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.readdata  = rdata;

    // Drain FSM: issue head entry, hold until acked, one idle bubble between drains.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    maddr_d  = ent_addr[head_q];
                    mwdata_d = ent_data[head_q];
                    req_d    = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    pop     = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ent_valid <= '0;
        end else begin
            if (push) begin
                tail_q            <= tail_q + PW'(1);
                ent_valid[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q            <= head_q + PW'(1);
                ent_valid[head_q] <= 1'b0;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail_q] <= bus.addr;
            ent_data[tail_q] <= bus.wdata;
        end
    end

    // Walk oldest to youngest so the youngest word match wins.
    always_comb begin
        rdata = bus.mem_rdata;
        idx   = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_q + PW'(k);
            if (ent_valid[idx] && (ent_addr[idx][AW-1:2] == bus.addr[AW-1:2])) begin
                rdata = ent_data[idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed self-checking bench for dmem_write_buffer.
module tb_dmem_write_buffer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic acc;
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    dmem_write_buffer_if #(.AW(32)) bus ();

    dmem_write_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite = 1'b1;
        bus.addr     = a;
        bus.wdata    = d;
        step();
        bus.memwrite = 1'b0;
        #1;
    endtask

    // Drain with ack held high, recording each issued write; retries a pending store.
    task automatic drain(input int budget);
        for (int c = 0; c < budget && !(bus.empty && !bus.memwrite); c++) begin
            if (bus.mem_req) begin
                got_a.push_back(bus.mem_addr);
                got_d.push_back(bus.mem_wdata);
            end
            acc = bus.memwrite && !bus.stall;
            step();
            if (acc) bus.memwrite = 1'b0;
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.memwrite  = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
`ifdef WBUF_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_req",   32'(bus.mem_req),   32'd0);
        chk("rst_addr",  bus.mem_addr,       32'd0);
        chk("rst_wdata", bus.mem_wdata,      32'd0);
        chk("rst_empty", 32'(bus.empty),     32'd1);

        // 1: single store, ack tied high
        bus.mem_ack  = 1'b1;
        bus.memwrite = 1'b1;
        bus.addr     = 32'h10;
        bus.wdata    = 32'hDEADBEEF;
        #1;
        chk("t1_stall", 32'(bus.stall), 32'd0);
        step();
        bus.memwrite = 1'b0;
        #1;
        chk("t1_req_n",   32'(bus.mem_req), 32'd0);
        chk("t1_empty_n", 32'(bus.empty),   32'd0);
        step();
        chk("t1_req_n1",  32'(bus.mem_req), 32'd1);
        chk("t1_addr",    bus.mem_addr,     32'h10);
        chk("t1_wdata",   bus.mem_wdata,    32'hDEADBEEF);
        step();
        chk("t1_req_off", 32'(bus.mem_req), 32'd0);
        chk("t1_empty",   32'(bus.empty),   32'd1);
        step();
        chk("t1_no_reissue", 32'(bus.mem_req), 32'd0);

        // 2: fill with ack low, fifth store stalls, then drain in order
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.memwrite = 1'b1;
            bus.addr     = 32'(i * 4);
            bus.wdata    = 32'(i * 4) + 32'h100;
            #1;
            chk("t2_fill_stall", 32'(bus.stall), 32'd0);
            step();
        end
        bus.addr  = 32'h20;
        bus.wdata = 32'h120;
        #1;
        chk("t2_stall", 32'(bus.stall), 32'd1);
        step();
        chk("t2_count", 32'(dut.count_q), 32'd4);
        chk("t2_stall_hold", 32'(bus.stall), 32'd1);
        bus.mem_ack = 1'b1;
        #1;
        got_a.delete();
        got_d.delete();
        drain(40);
        chk("t2_ndrain", 32'(got_a.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_a.size(); i++) begin
            chk("t2_order_addr", got_a[i], (i == 4) ? 32'h20 : 32'(i * 4));
            chk("t2_order_data", got_d[i], (i == 4) ? 32'h120 : 32'(i * 4) + 32'h100);
        end
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // 3: forwarding of youngest pending store
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h55;
        store(32'h40, 32'd1);
        store(32'h40, 32'd2);
        bus.addr = 32'h40;
        #1;
        chk("t3_fwd_40", bus.readdata, 32'd2);
        bus.addr = 32'h44;
        #1;
        chk("t3_miss_44", bus.readdata, 32'h55);
        chk("t3_raddr",   bus.mem_raddr, 32'h44);
        bus.addr = 32'h42;
        #1;
        chk("t3_fwd_42", bus.readdata, 32'd2);
        bus.memwrite = 1'b1;
        bus.addr     = 32'h48;
        bus.wdata    = 32'd9;
        #1;
        chk("t3_same_cycle", bus.readdata, 32'h55);
        step();
        bus.memwrite = 1'b0;
        #1;
        chk("t3_next_cycle", bus.readdata, 32'd9);
        store(32'h4C, 32'hC);

        // 4: full + BUSY, store and ack in the same cycle
        chk("t4_count_full", 32'(dut.count_q), 32'd4);
        chk("t4_busy_req",   32'(bus.mem_req), 32'd1);
        bus.memwrite = 1'b1;
        bus.addr     = 32'h50;
        bus.wdata    = 32'h50;
        bus.mem_ack  = 1'b1;
        #1;
        chk("t4_stall", 32'(bus.stall), 32'd1);
        step();
        bus.memwrite = 1'b0;
        bus.mem_ack  = 1'b0;
        #1;
        chk("t4_count", 32'(dut.count_q), 32'd3);
        chk("t4_req",   32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b1;
        got_a.delete();
        got_d.delete();
        drain(30);
        chk("t4_ndrain", 32'(got_a.size()), 32'd3);
        if (got_a.size() == 3) begin
            chk("t4_d0_addr", got_a[0], 32'h40);
            chk("t4_d0_data", got_d[0], 32'd2);
            chk("t4_d1_addr", got_a[1], 32'h48);
            chk("t4_d2_addr", got_a[2], 32'h4C);
        end

        // 5: asynchronous reset mid-BUSY with three entries
        bus.mem_ack = 1'b0;
        store(32'h60, 32'h6);
        store(32'h64, 32'h7);
        store(32'h68, 32'h8);
        chk("t5_req_busy", 32'(bus.mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_req_drop", 32'(bus.mem_req), 32'd0);
        chk("t5_empty",    32'(bus.empty),   32'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_req", 32'(bus.mem_req), 32'd0);
        end
        chk("t5_empty_after", 32'(bus.empty), 32'd1);

`ifdef WBUF_FLUSH_EN
        // 6: flush rejects all stores while pending entries drain
        store(32'h70, 32'h1);
        store(32'h74, 32'h2);
        bus.flush    = 1'b1;
        bus.memwrite = 1'b1;
        bus.addr     = 32'h78;
        bus.wdata    = 32'h3;
        bus.mem_ack  = 1'b1;
        got_a.delete();
        #1;
        for (int c = 0; c < 20 && !bus.empty; c++) begin
            chk("t6_stall", 32'(bus.stall), 32'd1);
            if (bus.mem_req) got_a.push_back(bus.mem_addr);
            step();
        end
        chk("t6_empty",  32'(bus.empty), 32'd1);
        chk("t6_ndrain", 32'(got_a.size()), 32'd2);
        bus.flush    = 1'b0;
        bus.memwrite = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
